// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states and next-PC select codes.
// No logic, no latency; pure type definitions.
// No flow control involved.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_RET,
      SEL_CALL,
      SEL_JUMP,
      SEL_BRANCH,
      SEL_INC
   } sel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address LIFO; a push while full overwrites the oldest entry.
// pop_data is combinational from the top entry; push/pop take effect on the next edge.
// No backpressure: the caller checks full/empty and never pushes and pops together.
module pc_ras #(
   parameter int N         = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [N-1:0] push_data,
   output logic [N-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(RAS_DEPTH);

   logic [N-1:0]  mem [RAS_DEPTH];
   logic [AW-1:0] top_ptr;   // next slot to write; wraps onto the oldest entry when full
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   assign rd_ptr   = top_ptr - AW'(1);
   assign pop_data = mem[rd_ptr];
   assign full     = (count == (AW+1)'(RAS_DEPTH));
   assign empty    = (count == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         top_ptr <= '0;
         count   <= '0;
      end else if (push) begin
         mem[top_ptr] <= push_data;
         top_ptr      <= top_ptr + AW'(1);
         if (!full) begin
            count <= count + (AW+1)'(1);
         end
      end else if (pop && !empty) begin
         top_ptr <= rd_ptr;
         count   <= count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and next-PC sequencer with IDLE/RUN/HALT control; return stack under PC_SEQ_RAS_EN.
// Latency 1: every next-PC decision appears on current_pc after one rising edge.
// stall holds the PC (and the stack) in RUN; pc_valid drops combinationally while stalled.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int           N         = 32,
   parameter logic [N-1:0] STEP      = N'(1),
   parameter logic [N-1:0] RESET_VEC = '0,
   parameter int           RAS_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         halt_req,
   input  logic         resume,
   input  logic         stall,
   input  logic         branch_en,
   input  logic [N-1:0] branch_offset,
   input  logic         jump_en,
   input  logic [N-1:0] jump_target,
   input  logic         call_en,
   input  logic         ret_en,
   output logic [N-1:0] current_pc,
   output logic         pc_valid,
   output logic         halted,
   output logic         ras_overflow,
   output logic         ras_underflow
);

   state_t       state, state_nxt;
   sel_t         sel;
   logic [N-1:0] pc_nxt;
   logic [N-1:0] pc_inc;
   logic         ret_req;
   logic         ras_empty;
   logic [N-1:0] ras_pop_data;

   assign pc_inc   = current_pc + STEP;
   assign pc_valid = (state == ST_RUN) && !stall;
   assign halted   = (state == ST_HALT);

`ifdef PC_SEQ_RAS_EN
   logic ras_full;
   logic ras_push;
   logic ras_pop;

   assign ret_req  = ret_en;
   assign ras_push = (sel == SEL_CALL);
   assign ras_pop  = (sel == SEL_RET) && !ras_empty;

   pc_ras #(
      .N         (N),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_inc),
      .pop_data  (ras_pop_data),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         if (ras_push && ras_full) begin
            ras_overflow <= 1'b1;
         end
         ras_underflow <= (sel == SEL_RET) && ras_empty;
      end
   end
`else
   // Without a stack, a return request never selects SEL_RET and call degenerates to jump.
   logic ret_unused;

   assign ret_unused    = ret_en;
   assign ret_req       = 1'b0;
   assign ras_empty     = 1'b1;
   assign ras_pop_data  = '0;
   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      sel       = SEL_HOLD;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (halt_req)       state_nxt = ST_HALT;
            else if (stall)     sel = SEL_HOLD;
            else if (ret_req)   sel = SEL_RET;
            else if (call_en)   sel = SEL_CALL;
            else if (jump_en)   sel = SEL_JUMP;
            else if (branch_en) sel = SEL_BRANCH;
            else                sel = SEL_INC;
         end
         ST_HALT: begin
            if (resume) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_nxt = current_pc;
      case (sel)
         SEL_RET:    pc_nxt = ras_empty ? pc_inc : ras_pop_data;
         SEL_CALL:   pc_nxt = jump_target;
         SEL_JUMP:   pc_nxt = jump_target;
         SEL_BRANCH: pc_nxt = current_pc + branch_offset;
         SEL_INC:    pc_nxt = pc_inc;
         default:    pc_nxt = current_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         current_pc <= RESET_VEC;
      end else begin
         state      <= state_nxt;
         current_pc <= pc_nxt;
      end
   end

endmodule
